// File: rtl/sa_ctrl_pkg.sv
// sa_ctrl_pkg: shared types and constant helpers for the systolic-array sequencer.
//   sa_state_t  : pass phases, in order IDLE -> LOAD -> STREAM -> FLUSH -> DRAIN -> DONE
//   row_w()     : width of a row index, max(1, $clog2(n))
//   flush_len() : wavefront flush length in cycles, 2n-2
package sa_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStream,
        StFlush,
        StDrain,
        StDone
    } sa_state_t;

    function automatic int unsigned row_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned flush_len(input int unsigned n);
        return 2 * n - 2;
    endfunction

endpackage

// File: rtl/sa_sequencer_if.sv
// sa_sequencer_if: host command / array control bundle of the sequencer.
//   master : host side  - drives start, k_len, abort, stall; observes status and enables
//   slave  : sequencer  - samples commands, drives busy, load_en/row, in_valid,
//                         out_valid/row, done, err, stall_cycles
interface sa_sequencer_if #(
    parameter int unsigned N   = 4,
    parameter int unsigned K_W = 8
);
    import sa_ctrl_pkg::*;

    localparam int unsigned RW = row_w(N);

    logic           start;
    logic [K_W-1:0] k_len;
    logic           abort;
    logic           stall;
    logic           busy;
    logic           load_en;
    logic [RW-1:0]  load_row;
    logic           in_valid;
    logic           out_valid;
    logic [RW-1:0]  out_row;
    logic           done;
    logic           err;
    logic [15:0]    stall_cycles;

    modport master (
        output start, k_len, abort, stall,
        input  busy, load_en, load_row, in_valid, out_valid, out_row, done, err, stall_cycles
    );

    modport slave (
        input  start, k_len, abort, stall,
        output busy, load_en, load_row, in_valid, out_valid, out_row, done, err, stall_cycles
    );

endinterface

// File: rtl/sa_step_counter.sv
// sa_step_counter: wrapping step counter.
//   clk, n_rst  : clock, asynchronous active-low reset
//   i_clear     : synchronous clear (highest priority)
//   i_enable    : advance by one this cycle
//   i_terminal  : number of steps; count runs 0..i_terminal-1 then wraps to 0
//   o_count     : current count
//   o_last      : count == terminal-1 and enabled, i.e. the final step is taken now
module sa_step_counter #(
    parameter int unsigned SIZE = 4
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic            i_clear,
    input  logic            i_enable,
    input  logic [SIZE-1:0] i_terminal,
    output logic [SIZE-1:0] o_count,
    output logic            o_last
);

    logic [SIZE-1:0] r_count;

    assign o_last  = i_enable && (r_count == i_terminal - SIZE'(1));
    assign o_count = r_count;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_count <= '0;
        end else if (i_clear || o_last) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + SIZE'(1);
        end
    end

endmodule

// File: rtl/sa_sequencer.sv
// sa_sequencer: sequences one matrix pass through an NxN systolic array.
//   clk, n_rst : clock, asynchronous active-low reset
//   bus.slave  : start/k_len/abort/stall in; busy, load_en/load_row, in_valid,
//                out_valid/out_row, done, err, stall_cycles out
// Optional: define SA_SEQ_PERF_CNT_EN to build the saturating stall_cycles counter;
// otherwise stall_cycles reads 0.
module sa_sequencer
    import sa_ctrl_pkg::*;
#(
    parameter int unsigned N   = 4,
    parameter int unsigned K_W = 8
) (
    input  logic           clk,
    input  logic           n_rst,
    sa_sequencer_if.slave  bus
);

    localparam int unsigned RW        = row_w(N);
    localparam int unsigned RCW       = RW + 1;  // must hold the terminal value N
    localparam int unsigned FCW       = RW + 2;  // must hold 2N-2
    localparam int unsigned FLUSH_LEN = flush_len(N);

    sa_state_t      r_state, w_state_next;
    logic [K_W-1:0] r_k_len;
    logic           r_err;

    logic           w_abort, w_accept;
    logic           w_row_en, w_row_last, w_str_en, w_str_last, w_fl_en, w_fl_last;
    logic [RCW-1:0] w_row_cnt;
    logic [K_W-1:0] w_str_cnt;
    logic [FCW-1:0] w_fl_cnt;
    logic           w_unused;

    // abort only acts on a pass in flight; in IDLE it just masks start
    assign w_abort  = bus.abort && (r_state != StIdle);
    assign w_accept = (r_state == StIdle) && bus.start && !bus.abort && (bus.k_len != '0);

    assign w_row_en = (r_state == StLoad) || ((r_state == StDrain) && !bus.stall);
    assign w_str_en = (r_state == StStream) && !bus.stall;
    assign w_fl_en  = (r_state == StFlush);

    // row counter is shared: it wraps to 0 at the end of LOAD, ready for DRAIN
    sa_step_counter #(.SIZE(RCW)) u_row_cnt (
        .clk        (clk),
        .n_rst      (n_rst),
        .i_clear    (w_abort),
        .i_enable   (w_row_en),
        .i_terminal (RCW'(N)),
        .o_count    (w_row_cnt),
        .o_last     (w_row_last)
    );

    sa_step_counter #(.SIZE(K_W)) u_str_cnt (
        .clk        (clk),
        .n_rst      (n_rst),
        .i_clear    (w_abort),
        .i_enable   (w_str_en),
        .i_terminal (r_k_len),
        .o_count    (w_str_cnt),
        .o_last     (w_str_last)
    );

    sa_step_counter #(.SIZE(FCW)) u_fl_cnt (
        .clk        (clk),
        .n_rst      (n_rst),
        .i_clear    (w_abort),
        .i_enable   (w_fl_en),
        .i_terminal (FCW'(FLUSH_LEN)),
        .o_count    (w_fl_cnt),
        .o_last     (w_fl_last)
    );

    assign w_unused = ^{w_str_cnt, w_fl_cnt, w_row_cnt[RCW-1]};

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:   if (w_accept) w_state_next = StLoad;
            StLoad:   if (w_row_last) w_state_next = StStream;
            StStream: if (w_str_last) w_state_next = (N == 1) ? StDrain : StFlush;
            StFlush:  if (w_fl_last) w_state_next = StDrain;
            StDrain:  if (w_row_last) w_state_next = StDone;
            StDone:   w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
        if (w_abort) w_state_next = StIdle;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= StIdle;
            r_k_len <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_err   <= (r_state == StIdle) && bus.start && !bus.abort && (bus.k_len == '0);
            if (w_accept) r_k_len <= bus.k_len;
        end
    end

    assign bus.busy      = (r_state != StIdle);
    assign bus.load_en   = (r_state == StLoad);
    assign bus.load_row  = (r_state == StLoad) ? w_row_cnt[RW-1:0] : '0;
    assign bus.in_valid  = (r_state == StStream) && !bus.stall;
    assign bus.out_valid = (r_state == StDrain) && !bus.stall;
    assign bus.out_row   = (r_state == StDrain) ? w_row_cnt[RW-1:0] : '0;
    assign bus.done      = (r_state == StDone);
    assign bus.err       = r_err;

`ifdef SA_SEQ_PERF_CNT_EN
    logic [15:0] r_stall_cycles;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_stall_cycles <= '0;
        end else if (w_accept) begin
            r_stall_cycles <= '0;
        end else if (((r_state == StStream) || (r_state == StDrain)) && bus.stall &&
                     (r_stall_cycles != 16'hFFFF)) begin
            r_stall_cycles <= r_stall_cycles + 16'd1;
        end
    end

    assign bus.stall_cycles = r_stall_cycles;
`else
    assign bus.stall_cycles = '0;
`endif

endmodule

// File: tb/tb_sa_sequencer.sv
// tb_sa_sequencer: table-driven passes with a row scoreboard, plus hand-written
// sequences for err, abort, and reset mid-pass.
module tb_sa_sequencer;

    localparam int unsigned N   = 4;
    localparam int unsigned K_W = 8;

    typedef struct {
        int k;
        int stall_from;
        int stall_len;
        int restart_c;
        int exp_done;
        int exp_beats;
        int exp_stalls;
    } vec_t;

    logic clk;
    logic n_rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sa_sequencer_if #(.N(N), .K_W(K_W)) bus ();

    sa_sequencer #(.N(N), .K_W(K_W)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int q_load[$];
    int q_out[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int all_outputs();
        return int'({bus.busy, bus.load_en, bus.load_row, bus.in_valid, bus.out_valid,
                     bus.out_row, bus.done, bus.err, bus.stall_cycles});
    endfunction

    task automatic do_start(input int k);
        @(negedge clk);
        bus.start = 1'b1;
        bus.k_len = K_W'(k);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Cycle 0 carries start; cycle c is the period after edge c-1.
    task automatic run_pass(input vec_t v, input string tag);
        int c, beats, first_beat, done_c, exp_st, er;
        for (int i = 0; i < int'(N); i++) begin
            q_load.push_back(i);
            q_out.push_back(i);
        end
        beats = 0;
        first_beat = -1;
        done_c = -1;
        @(negedge clk);
        bus.start = 1'b1;
        bus.k_len = K_W'(v.k);
        bus.stall = 1'b0;
        bus.abort = 1'b0;
        @(posedge clk);
        #1;
        c = 1;
        while (done_c < 0 && c < 400) begin
            bus.stall = (c >= v.stall_from) && (c < v.stall_from + v.stall_len);
            if (c == v.restart_c) begin
                bus.start = 1'b1;
                bus.k_len = K_W'(9);
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            check({tag, "/busy"}, int'(bus.busy), 1);
            if (bus.stall)
                check({tag, "/valid_while_stall"}, int'(bus.in_valid | bus.out_valid), 0);
            if (bus.load_en) begin
                if (q_load.size() == 0) begin
                    check({tag, "/load_extra"}, int'(bus.load_row), -1);
                end else begin
                    er = q_load.pop_front();
                    check({tag, "/load_row"}, int'(bus.load_row), er);
                end
            end
            if (bus.out_valid) begin
                if (q_out.size() == 0) begin
                    check({tag, "/out_extra"}, int'(bus.out_row), -1);
                end else begin
                    er = q_out.pop_front();
                    check({tag, "/out_row"}, int'(bus.out_row), er);
                end
            end
            if (bus.in_valid) begin
                beats++;
                if (first_beat < 0) first_beat = c;
            end
            if (bus.done) done_c = c;
            @(posedge clk);
            #1;
            c++;
        end
        bus.stall = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check({tag, "/done_after"}, int'(bus.done), 0);
        check({tag, "/busy_after"}, int'(bus.busy), 0);
        check({tag, "/done_cycle"}, done_c, v.exp_done);
        check({tag, "/beats"}, beats, v.exp_beats);
        check({tag, "/first_beat"}, first_beat, 5);
        check({tag, "/load_rows_left"}, q_load.size(), 0);
        check({tag, "/out_rows_left"}, q_out.size(), 0);
`ifdef SA_SEQ_PERF_CNT_EN
        exp_st = v.exp_stalls;
`else
        exp_st = 0;
`endif
        check({tag, "/stall_cycles"}, int'(bus.stall_cycles), exp_st);
        q_load.delete();
        q_out.delete();
    endtask

    initial begin
        vec_t vecs[9];
        int ndone;

        n_rst = 1'b0;
        bus.start = 1'b0;
        bus.k_len = '0;
        bus.abort = 1'b0;
        bus.stall = 1'b0;

        //          k   stall_from len restart done beats stalls
        vecs[0] = '{8,   0,  0,  0,  23,  8,   0};  // nominal
        vecs[1] = '{8,   8,  3,  0,  26,  8,   3};  // stall in STREAM after beat 2
        vecs[2] = '{8,   20, 2,  0,  25,  8,   2};  // stall in DRAIN at out_row 1
        vecs[3] = '{3,   1,  2,  0,  18,  3,   0};  // stall in LOAD ignored
        vecs[4] = '{2,   8,  2,  0,  17,  2,   0};  // stall in FLUSH ignored
        vecs[5] = '{2,   0,  0,  3,  17,  2,   0};  // start while busy ignored
        vecs[6] = '{2,   0,  0,  17, 17,  2,   0};  // start in DONE ignored
        vecs[7] = '{255, 0,  0,  0,  270, 255, 0};  // max k_len, no wrap
        vecs[8] = '{5,   7,  1,  0,  21,  5,   1};

        #12;
        check("reset_outputs", all_outputs(), 0);
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        check("idle_outputs", all_outputs(), 0);

        for (int i = 0; i < 9; i++) run_pass(vecs[i], $sformatf("vec%0d", i));

        // k_len == 0: one-cycle err, never busy
        do_start(0);
        @(negedge clk);
        check("err_pulse", int'(bus.err), 1);
        check("err_busy", int'(bus.busy), 0);
        @(negedge clk);
        check("err_clear", int'(bus.err), 0);
        check("err_busy2", int'(bus.busy), 0);
        run_pass('{1, 0, 0, 0, 16, 1, 0}, "k1");

        // abort together with start in IDLE: start ignored
        @(negedge clk);
        bus.start = 1'b1;
        bus.k_len = K_W'(4);
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        @(negedge clk);
        check("idle_abort_busy", int'(bus.busy), 0);
        check("idle_abort_err", int'(bus.err), 0);

        // abort in STREAM while beat 4 is presented
        do_start(8);
        repeat (8) @(posedge clk);
        #1;
        bus.abort = 1'b1;
        @(negedge clk);
        check("abort_at_beat4", int'(bus.in_valid), 1);
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        @(negedge clk);
        check("abort_busy", int'(bus.busy), 0);
        check("abort_in_valid", int'(bus.in_valid), 0);
        ndone = 0;
        repeat (20) begin
            @(negedge clk);
            ndone += int'(bus.done);
        end
        check("abort_no_done", ndone, 0);
        run_pass(vecs[0], "post_abort");

        // reset mid-DRAIN: outputs drop immediately
        do_start(8);
        repeat (19) @(posedge clk);
        @(negedge clk);
        check("pre_reset_out_row", int'(bus.out_row), 1);
        check("pre_reset_out_valid", int'(bus.out_valid), 1);
        #2;
        n_rst = 1'b0;
        #1;
        check("mid_reset_outputs", all_outputs(), 0);
        @(negedge clk);
        n_rst = 1'b1;
        run_pass(vecs[0], "post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sa_sequencer.md
Name: sa_sequencer

Overview:
- Top-level controller that sequences one matrix pass through the NxN systolic array.
- Phases, in order: weight load (one row per cycle), activation streaming for k_len beats with backpressure, wavefront flush, result drain (one row per beat), then a one-cycle done pulse.
- Drives the array's load, feed and drain enables and row indices. Sits between the host command interface and the array/output buffer.

Parameters:
- N, 4, array dimension (rows = cols); N >= 1
- K_W, 8, width of k_len and the stream-beat counter

Ports:
- clk  in  1  system clock, rising edge
- n_rst  in  1  asynchronous active-low reset
- start  in  1  begin a pass; sampled only in IDLE
- k_len  in  K_W  activation beats to stream; latched on accepted start
- abort  in  1  synchronous abort; wins over all other inputs
- stall  in  1  downstream backpressure (output buffer full)
- busy  out  1  high in every state except IDLE
- load_en  out  1  weight-row write enable
- load_row  out  max(1,$clog2(N))  weight row being written
- in_valid  out  1  activation beat presented to array edge
- out_valid  out  1  result row presented to output buffer
- out_row  out  max(1,$clog2(N))  result row index
- done  out  1  one-cycle pulse at end of a pass
- err  out  1  one-cycle pulse: start with k_len == 0
- stall_cycles  out  16  stall counter (see Optional Feature)

Behaviour:
- Reset (n_rst low, asynchronous): state = IDLE, all counters 0, latched k_len 0. Every output is 0.
- States (sa_state_t): IDLE, LOAD, STREAM, FLUSH, DRAIN, DONE.
- Output timing: load_en, load_row, out_row, busy, done and err decode from registered state and counters. in_valid and out_valid also gate combinationally with !stall.
- IDLE:
  - start && k_len != 0 -> latch k_len, go to LOAD.
  - start && k_len == 0 -> err = 1 next cycle, stay IDLE.
- LOAD:
  - Exactly N cycles, load_en = 1, load_row = 0..N-1; stall is ignored.
  - After row N-1 -> STREAM.
- STREAM:
  - in_valid = !stall. The beat counter advances only on cycles with in_valid = 1.
  - After the beat with index k_len-1 is accepted -> FLUSH.
- FLUSH:
  - Exactly 2N-2 cycles, no outputs asserted, stall ignored; then -> DRAIN.
  - N = 1: FLUSH is skipped; STREAM goes directly to DRAIN.
- DRAIN:
  - out_valid = !stall, out_row = 0..N-1. The row index advances only on cycles with out_valid = 1.
  - After row N-1 is accepted -> DONE.
- DONE: done = 1 for exactly one cycle, then -> IDLE. A start in DONE is ignored.
- start while busy: ignored; the latched k_len is not changed.
- abort:
  - In any non-IDLE state: next state IDLE, counters cleared, no done pulse.
  - In IDLE: no effect; start in the same cycle is ignored.
- No-stall latency: start sampled at edge 0 -> done high in cycle 4N + k_len - 1 (N=4, k_len=8 -> cycle 23).
- Counters: all terminal checks use ==. The stream counter is K_W bits, so k_len = 2^K_W - 1 completes without wrap.
- Reset mid-pass: immediate return to IDLE with all outputs 0.

Optional Feature:
- Macro: SA_SEQ_PERF_CNT_EN
- Defined:
  - stall_cycles counts cycles in STREAM or DRAIN with stall = 1.
  - Saturates at 16'hFFFF; cleared to 0 on an accepted start; holds its value in IDLE.
- Undefined: the stall_cycles port still exists, tied to 0, and no counter logic is built.

Decomposition:
- Package sa_ctrl_pkg:
  - sa_state_t enum.
  - Constant helpers for row width (max(1,$clog2(N))) and flush length (2N-2).
- Sub-module sa_step_counter (parameter SIZE):
  - Inputs: clear, enable, terminal value.
  - Outputs: count and a last flag (count == terminal-1 && enable).
  - Three instances: row counter shared by LOAD and DRAIN, stream counter, flush counter.

Test Plan:
- Nominal, N=4, k_len=8, no stall -> load_row 0..3 in cycles 1-4; in_valid cycles 5-12; out_row 0..3 in cycles 19-22; done pulse in cycle 23 only.
- Stall in STREAM: stall high for 3 cycles after beat 2 -> exactly 8 in_valid beats; done delayed to cycle 26; stall_cycles = 3 with macro, 0 without.
- Stall in DRAIN: stall high while out_row = 1 for 2 cycles -> out_row holds 1, out_valid low while stalled; rows 0..3 each accepted once.
- start with k_len = 0 -> err pulse 1 cycle, busy stays 0; a following start with k_len = 1 -> done in cycle 16 (N=4).
- abort in STREAM at beat 4 -> IDLE next cycle, busy 0, no done; a new start runs a full, correct pass.
- n_rst asserted mid-DRAIN -> all outputs 0 immediately; after release, start behaves as the nominal case.
